// File: rtl/n_set_cache_multi_policy_controller_if.sv
// Request/response bundle between the cache controller and its victim-address generator.
//
// Handshake: a miss request is a one-cycle miss_i pulse with addr_i carrying the set.
// While a miss is in flight, further miss_i pulses are ignored.
// The response is a one-cycle done_o pulse, one cycle after the miss is accepted.
// addr_o is valid while done_o is high, and holds its value until the next done_o.
// hit_i is a fire-and-forget strobe with no response.
// There is no backpressure on either side.
interface n_set_cache_multi_policy_controller_if #(
  parameter int BW = 7
);
  logic          hit_i;
  logic          miss_i;
  logic [BW-1:0] addr_i;
  logic          done_o;
  logic [BW-1:0] addr_o;
  logic          state_dbg_o;

  modport master (
    output hit_i, miss_i, addr_i,
    input  done_o, addr_o, state_dbg_o
  );

  modport slave (
    input  hit_i, miss_i, addr_i,
    output done_o, addr_o, state_dbg_o
  );
endinterface

// File: rtl/n_set_cache_multi_policy_controller.sv
// Victim-address generator for an n-way set-associative cache.
// The replacement policy is fixed per instance: random LFSR, per-set FIFO pointer, or true LRU.
module n_set_cache_multi_policy_controller #(
  parameter int          CACHE_BLOCK_CAPACITY = 128,
  parameter int          CACHE_SET_SIZE       = 4,
  parameter int          POLICY               = 0,
  parameter logic [11:0] LFSR_SEED            = 12'hA11
) (
  input  logic clock_i,
  input  logic reset_i,
  n_set_cache_multi_policy_controller_if.slave bus
);
  localparam int BW_CAP = $clog2(CACHE_BLOCK_CAPACITY);
  localparam int BW_GRP = $clog2(CACHE_SET_SIZE);
  localparam int BW_SET = BW_CAP - BW_GRP;
  localparam int N_SET  = CACHE_BLOCK_CAPACITY / CACHE_SET_SIZE;
  localparam int GW     = (BW_GRP > 0) ? BW_GRP : 1;
  localparam int SW     = (BW_SET > 0) ? BW_SET : 1;

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_e;

  state_e              state_q, state_d;
  logic                done_q, done_d;
  logic [BW_CAP-1:0]   addr_q, addr_d;
  logic [SW-1:0]       req_set;
  logic [GW-1:0]       victim;
  logic [BW_CAP-1:0]   victim_addr;
  logic                miss_acc;

  // Zero-width fields collapse to constant zero so single-set and direct-mapped builds elaborate.
  if (BW_SET > 0) begin : g_set
    assign req_set = bus.addr_i[BW_SET-1:0];
  end else begin : g_noset
    assign req_set = '0;
  end

  if (BW_SET == 0) begin : g_va_way
    assign victim_addr = victim[BW_CAP-1:0];
  end else if (BW_GRP == 0) begin : g_va_set
    assign victim_addr = req_set[BW_CAP-1:0];
  end else begin : g_va_both
    assign victim_addr = {victim[BW_GRP-1:0], req_set[BW_SET-1:0]};
  end

  assign miss_acc = (state_q == IDLE) && bus.miss_i;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (bus.miss_i) begin
          state_d = RESP;
          done_d  = 1'b1;
          addr_d  = victim_addr;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
    end
  end

  assign bus.done_o      = done_q;
  assign bus.addr_o      = addr_q;
  assign bus.state_dbg_o = state_q;

  if (POLICY == 1) begin : g_fifo
    logic [GW-1:0] ptr_q [N_SET];
    logic [GW-1:0] ptr_d [N_SET];

    assign victim = ptr_q[req_set];

    always_comb begin
      ptr_d = ptr_q;
      if (miss_acc) begin
        ptr_d[req_set] = (ptr_q[req_set] == GW'(CACHE_SET_SIZE - 1)) ? '0 : ptr_q[req_set] + 1'b1;
      end
    end

    always_ff @(posedge clock_i) begin
      if (reset_i) begin
        for (int s = 0; s < N_SET; s++) ptr_q[s] <= '0;
      end else begin
        ptr_q <= ptr_d;
      end
    end
  end else if (POLICY == 2) begin : g_lru
    logic [GW-1:0] age_q [N_SET][CACHE_SET_SIZE];
    logic [GW-1:0] age_d [N_SET][CACHE_SET_SIZE];
    logic [GW-1:0] req_way;
    logic          touch_en;
    logic [GW-1:0] touch_way;
    logic [GW-1:0] touch_old;

    if (BW_GRP > 0) begin : g_way
      assign req_way = bus.addr_i[BW_CAP-1:BW_SET];
    end else begin : g_noway
      assign req_way = '0;
    end

    // An accepted miss owns the update slot; a coincident hit is dropped.
    assign touch_en  = miss_acc || bus.hit_i;
    assign touch_way = miss_acc ? victim : req_way;
    assign touch_old = age_q[req_set][touch_way];

    always_comb begin
      victim = '0;
      for (int w = 0; w < CACHE_SET_SIZE; w++) begin
        if (age_q[req_set][w] == GW'(CACHE_SET_SIZE - 1)) victim = GW'(w);
      end
    end

    always_comb begin
      age_d = age_q;
      if (touch_en) begin
        for (int w = 0; w < CACHE_SET_SIZE; w++) begin
          if (GW'(w) == touch_way) begin
            age_d[req_set][w] = '0;
          end else if (age_q[req_set][w] < touch_old) begin
            age_d[req_set][w] = age_q[req_set][w] + 1'b1;
          end
        end
      end
    end

    always_ff @(posedge clock_i) begin
      if (reset_i) begin
        for (int s = 0; s < N_SET; s++) begin
          for (int w = 0; w < CACHE_SET_SIZE; w++) age_q[s][w] <= GW'(w);
        end
      end else begin
        age_q <= age_d;
      end
    end
  end else begin : g_rand
    logic [11:0] lfsr_q, lfsr_d;
    logic        fb;

    // x^12 + x^6 + x^4 + x + 1, stepped only when a miss is actually accepted.
    assign fb     = lfsr_q[11] ^ lfsr_q[5] ^ lfsr_q[3] ^ lfsr_q[0];
    assign lfsr_d = miss_acc ? {lfsr_q[10:0], fb} : lfsr_q;

    if (BW_GRP > 0) begin : g_pick
      assign victim = lfsr_q[GW-1:0];
    end else begin : g_zero
      assign victim = '0;
    end

    always_ff @(posedge clock_i) begin
      if (reset_i) lfsr_q <= LFSR_SEED;
      else         lfsr_q <= lfsr_d;
    end
  end
endmodule
